// File: rtl/systolic_array.sv
// systolic_array: 2x2 weight-stationary MAC array in signed fixed point, partial sums flowing down.
// Define SYSTOLIC_SATURATE_EN to saturate the scaled product and the accumulation instead of wrapping.

module systolic_pe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] input_in,
    input  logic [DATA_W-1:0] psum_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              valid_in,
    input  logic              accept_w,
    input  logic              switch_in,
    output logic [DATA_W-1:0] input_out,
    output logic [DATA_W-1:0] psum_out,
    output logic [DATA_W-1:0] weight_out,
    output logic              valid_out,
    output logic              switch_out
);
    logic [DATA_W-1:0]          wsh_reg;
    logic [DATA_W-1:0]          wact_reg;
    logic [DATA_W-1:0]          input_out_reg;
    logic [DATA_W-1:0]          psum_out_reg;
    logic                       valid_out_reg;
    logic                       switch_out_reg;
    logic signed [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]          scaled;
    logic [DATA_W-1:0]          psum_next;

    assign product = $signed(input_in) * $signed(wact_reg);

`ifdef SYSTOLIC_SATURATE_EN
    localparam logic signed [2*DATA_W-1:0] WIDE_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] WIDE_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]          SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]          SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] shifted;
    logic [DATA_W:0]            sum_wide;

    always_comb begin
        shifted = product >>> FRAC_W;
        if (shifted > WIDE_MAX) begin
            scaled = SAT_MAX;
        end else if (shifted < WIDE_MIN) begin
            scaled = SAT_MIN;
        end else begin
            scaled = shifted[DATA_W-1:0];
        end
        // One guard bit is enough to detect overflow of a two-operand sum.
        sum_wide = {psum_in[DATA_W-1], psum_in} + {scaled[DATA_W-1], scaled};
        if (sum_wide[DATA_W] != sum_wide[DATA_W-1]) begin
            psum_next = sum_wide[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            psum_next = sum_wide[DATA_W-1:0];
        end
    end
`else
    logic unused_product;

    // Arithmetic shift then truncation is just a bit-field of the full product.
    assign scaled         = product[FRAC_W +: DATA_W];
    assign psum_next      = psum_in + scaled;
    assign unused_product = ^product;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsh_reg        <= '0;
            wact_reg       <= '0;
            input_out_reg  <= '0;
            psum_out_reg   <= '0;
            valid_out_reg  <= 1'b0;
            switch_out_reg <= 1'b0;
        end else begin
            if (accept_w) begin
                wsh_reg <= weight_in;
            end
            // Copies the pre-edge shadow, so a simultaneous shift lands only in the shadow.
            if (switch_in) begin
                wact_reg <= wsh_reg;
            end
            switch_out_reg <= switch_in;
            if (valid_in) begin
                psum_out_reg  <= psum_next;
                input_out_reg <= input_in;
                valid_out_reg <= 1'b1;
            end else begin
                psum_out_reg  <= '0;
                input_out_reg <= '0;
                valid_out_reg <= 1'b0;
            end
        end
    end

    assign input_out  = input_out_reg;
    assign psum_out   = psum_out_reg;
    assign weight_out = wsh_reg;
    assign valid_out  = valid_out_reg;
    assign switch_out = switch_out_reg;
endmodule

module systolic_array #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sys_data_in_1x,
    input  logic [DATA_W-1:0] sys_data_in_2x,
    input  logic              sys_start,
    input  logic [DATA_W-1:0] sys_weight_in_x1,
    input  logic [DATA_W-1:0] sys_weight_in_x2,
    input  logic              sys_accept_w_1,
    input  logic              sys_accept_w_2,
    input  logic              sys_switch_in,
    output logic [DATA_W-1:0] sys_data_out_x1,
    output logic [DATA_W-1:0] sys_data_out_x2,
    output logic              sys_valid_out_x1,
    output logic              sys_valid_out_x2
);
    logic [DATA_W-1:0] row_data   [2];
    logic [DATA_W-1:0] col_weight [2];
    logic              col_accept [2];

    logic [DATA_W-1:0] pe_input_in   [2][2];
    logic [DATA_W-1:0] pe_psum_in    [2][2];
    logic [DATA_W-1:0] pe_weight_in  [2][2];
    logic              pe_valid_in   [2][2];
    logic              pe_switch_in  [2][2];
    logic [DATA_W-1:0] pe_input_out  [2][2];
    logic [DATA_W-1:0] pe_psum_out   [2][2];
    logic [DATA_W-1:0] pe_weight_out [2][2];
    logic              pe_valid_out  [2][2];
    logic              pe_switch_out [2][2];
    logic              unused_edges;

    assign row_data[0]   = sys_data_in_1x;
    assign row_data[1]   = sys_data_in_2x;
    assign col_weight[0] = sys_weight_in_x1;
    assign col_weight[1] = sys_weight_in_x2;
    assign col_accept[0] = sys_accept_w_1;
    assign col_accept[1] = sys_accept_w_2;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_row
            for (gj = 0; gj < 2; gj++) begin : g_col
                if (gj == 0) begin : g_left
                    assign pe_input_in[gi][gj] = row_data[gi];
                end else begin : g_right
                    assign pe_input_in[gi][gj] = pe_input_out[gi][gj-1];
                end

                if (gi == 0) begin : g_top
                    assign pe_psum_in[gi][gj]   = '0;
                    assign pe_weight_in[gi][gj] = col_weight[gj];
                end else begin : g_below
                    assign pe_psum_in[gi][gj]   = pe_psum_out[gi-1][gj];
                    assign pe_weight_in[gi][gj] = pe_weight_out[gi-1][gj];
                end

                // Valid runs along row 1 and down column 1; the switch wave runs down each column from row 1.
                if (gj > 0) begin : g_valid_left
                    assign pe_valid_in[gi][gj] = pe_valid_out[gi][gj-1];
                end else if (gi > 0) begin : g_valid_up
                    assign pe_valid_in[gi][gj] = pe_valid_out[gi-1][0];
                end else begin : g_valid_edge
                    assign pe_valid_in[gi][gj] = sys_start;
                end

                if (gi > 0) begin : g_switch_up
                    assign pe_switch_in[gi][gj] = pe_switch_out[gi-1][gj];
                end else if (gj > 0) begin : g_switch_left
                    assign pe_switch_in[gi][gj] = pe_switch_out[0][gj-1];
                end else begin : g_switch_edge
                    assign pe_switch_in[gi][gj] = sys_switch_in;
                end

                systolic_pe #(
                    .DATA_W(DATA_W),
                    .FRAC_W(FRAC_W)
                ) u_pe (
                    .clk        (clk),
                    .rst        (rst),
                    .input_in   (pe_input_in[gi][gj]),
                    .psum_in    (pe_psum_in[gi][gj]),
                    .weight_in  (pe_weight_in[gi][gj]),
                    .valid_in   (pe_valid_in[gi][gj]),
                    .accept_w   (col_accept[gj]),
                    .switch_in  (pe_switch_in[gi][gj]),
                    .input_out  (pe_input_out[gi][gj]),
                    .psum_out   (pe_psum_out[gi][gj]),
                    .weight_out (pe_weight_out[gi][gj]),
                    .valid_out  (pe_valid_out[gi][gj]),
                    .switch_out (pe_switch_out[gi][gj])
                );
            end
        end
    endgenerate

    assign unused_edges = ^{pe_input_out[0][1], pe_input_out[1][1],
                            pe_weight_out[1][0], pe_weight_out[1][1],
                            pe_switch_out[1][0], pe_switch_out[1][1],
                            pe_valid_out[0][1]};

    assign sys_data_out_x1  = pe_psum_out[1][0];
    assign sys_data_out_x2  = pe_psum_out[1][1];
    assign sys_valid_out_x1 = pe_valid_out[1][0];
    assign sys_valid_out_x2 = pe_valid_out[1][1];
endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: randomized and directed streams checked against an arithmetic matrix-product model.
module tb_systolic_array;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] sys_data_in_1x = '0;
    logic [DATA_W-1:0] sys_data_in_2x = '0;
    logic              sys_start = 1'b0;
    logic [DATA_W-1:0] sys_weight_in_x1 = '0;
    logic [DATA_W-1:0] sys_weight_in_x2 = '0;
    logic              sys_accept_w_1 = 1'b0;
    logic              sys_accept_w_2 = 1'b0;
    logic              sys_switch_in = 1'b0;
    logic [DATA_W-1:0] sys_data_out_x1;
    logic [DATA_W-1:0] sys_data_out_x2;
    logic              sys_valid_out_x1;
    logic              sys_valid_out_x2;

    int total = 0;
    int bad   = 0;

    // Sample s is row [sa0[s], sa1[s]] of A; sv[s] is its start flag.
    logic [15:0] sa0 [16];
    logic [15:0] sa1 [16];
    logic        sv  [16];
    logic [15:0] obs_x1 [16];
    logic [15:0] obs_x2 [16];
    logic [15:0] wcur  [2][2];
    logic [15:0] wnext [2][2];

    systolic_array #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .sys_data_in_1x   (sys_data_in_1x),
        .sys_data_in_2x   (sys_data_in_2x),
        .sys_start        (sys_start),
        .sys_weight_in_x1 (sys_weight_in_x1),
        .sys_weight_in_x2 (sys_weight_in_x2),
        .sys_accept_w_1   (sys_accept_w_1),
        .sys_accept_w_2   (sys_accept_w_2),
        .sys_switch_in    (sys_switch_in),
        .sys_data_out_x1  (sys_data_out_x1),
        .sys_data_out_x2  (sys_data_out_x2),
        .sys_valid_out_x1 (sys_valid_out_x1),
        .sys_valid_out_x2 (sys_valid_out_x2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] clamp16(input longint v);
        longint r;
        r = v;
`ifdef SYSTOLIC_SATURATE_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    function automatic logic [15:0] scale_mul(input logic [15:0] a, input logic [15:0] w);
        longint p;
        p = longint'($signed(a)) * longint'($signed(w));
        return clamp16(p >>> FRAC_W);
    endfunction

    function automatic logic [15:0] add_q(input logic [15:0] x, input logic [15:0] y);
        return clamp16(longint'($signed(x)) + longint'($signed(y)));
    endfunction

    function automatic logic [15:0] expect_c(input int s, input int col, input bit use_new);
        logic [15:0] w0, w1;
        w0 = use_new ? wnext[0][col] : wcur[0][col];
        w1 = use_new ? wnext[1][col] : wcur[1][col];
        return add_q(scale_mul(sa0[s], w0), scale_mul(sa1[s], w1));
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_col(input int s, input int n, input int col, input int switch_at,
                             input logic v_obs, input logic [15:0] d_obs);
        logic        v_exp;
        logic [15:0] d_exp;
        v_exp = 1'b0;
        d_exp = '0;
        if (s >= 0 && s < n) begin
            if (sv[s]) begin
                v_exp = 1'b1;
                d_exp = expect_c(s, col, switch_at >= 0 && s > switch_at);
            end
            if (col == 0) obs_x1[s] = d_obs;
            else          obs_x2[s] = d_obs;
            $display("sample %0d col%0d valid=%0b data=%h expect valid=%0b data=%h",
                     s, col + 1, v_obs, d_obs, v_exp, d_exp);
        end
        check($sformatf("valid_x%0d[%0d]", col + 1, s), {15'b0, v_obs}, {15'b0, v_exp});
        check($sformatf("data_x%0d[%0d]", col + 1, s), d_obs, d_exp);
    endtask

    task automatic set_idle();
        sys_start      = 1'b0;
        sys_accept_w_1 = 1'b0;
        sys_accept_w_2 = 1'b0;
        sys_switch_in  = 1'b0;
    endtask

    // Shift wnext into the shadows (row-2 weights first), pulse switch, let the wave settle.
    task automatic load_and_switch();
        @(negedge clk);
        sys_accept_w_1 = 1'b1; sys_accept_w_2 = 1'b1;
        sys_weight_in_x1 = wnext[1][0]; sys_weight_in_x2 = wnext[1][1];
        @(negedge clk);
        sys_weight_in_x1 = wnext[0][0]; sys_weight_in_x2 = wnext[0][1];
        @(negedge clk);
        sys_accept_w_1 = 1'b0; sys_accept_w_2 = 1'b0;
        sys_weight_in_x1 = 16'($urandom); sys_weight_in_x2 = 16'($urandom);
        sys_switch_in = 1'b1;
        @(negedge clk);
        sys_switch_in = 1'b0;
        repeat (3) @(negedge clk);
        wcur = wnext;
    endtask

    // Row-1 sample c is driven in iteration c, row-2 one iteration later; x1 shows it two
    // iterations later, x2 three. Samples after the switch iteration use wnext.
    task automatic run_stream(input int n, input int load_at, input int switch_at);
        bit ld0, ld1;
        for (int c = 0; c <= n + 2; c++) begin
            @(negedge clk);
            check_col(c - 2, n, 0, switch_at, sys_valid_out_x1, sys_data_out_x1);
            check_col(c - 3, n, 1, switch_at, sys_valid_out_x2, sys_data_out_x2);
            sys_start      = (c < n) ? sv[c] : 1'b0;
            sys_data_in_1x = (c < n && sv[c]) ? sa0[c] : 16'($urandom);
            sys_data_in_2x = (c >= 1 && c <= n) ? sa1[c-1] : 16'($urandom);
            ld0 = (load_at >= 0 && c == load_at);
            ld1 = (load_at >= 0 && c == load_at + 1);
            sys_accept_w_1 = ld0 || ld1;
            sys_accept_w_2 = ld0 || ld1;
            if (ld0) begin
                sys_weight_in_x1 = wnext[1][0]; sys_weight_in_x2 = wnext[1][1];
            end else if (ld1) begin
                sys_weight_in_x1 = wnext[0][0]; sys_weight_in_x2 = wnext[0][1];
            end else begin
                sys_weight_in_x1 = 16'($urandom); sys_weight_in_x2 = 16'($urandom);
            end
            sys_switch_in = (c == switch_at);
        end
        set_idle();
        if (switch_at >= 0) wcur = wnext;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            sa0[i] = '0; sa1[i] = '0; sv[i] = 1'b0; obs_x1[i] = '0; obs_x2[i] = '0;
        end
        wcur  = '{'{16'h0000, 16'h0000}, '{16'h0000, 16'h0000}};
        wnext = wcur;

        // Asynchronous reset before any clock edge, then idle after release.
        #2 rst = 1'b1;
        #1;
        check("rst_data_x1", sys_data_out_x1, 16'h0000);
        check("rst_data_x2", sys_data_out_x2, 16'h0000);
        check("rst_valid_x1", {15'b0, sys_valid_out_x1}, 16'h0000);
        check("rst_valid_x2", {15'b0, sys_valid_out_x2}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_data_x1", sys_data_out_x1, 16'h0000);
        check("idle_data_x2", sys_data_out_x2, 16'h0000);
        check("idle_valid_x1", {15'b0, sys_valid_out_x1}, 16'h0000);
        check("idle_valid_x2", {15'b0, sys_valid_out_x2}, 16'h0000);

        // Identity weights: C = A.
        wnext = '{'{16'h0100, 16'h0000}, '{16'h0000, 16'h0100}};
        load_and_switch();
        sa0[0] = 16'h0100; sa1[0] = 16'h0200; sv[0] = 1'b1;
        sa0[1] = 16'h0500; sa1[1] = 16'h0600; sv[1] = 1'b1;
        run_stream(2, -1, -1);
        check("ident_x1_0", obs_x1[0], 16'h0100);
        check("ident_x1_1", obs_x1[1], 16'h0500);
        check("ident_x2_0", obs_x2[0], 16'h0200);
        check("ident_x2_1", obs_x2[1], 16'h0600);

        // W = [[0.5, 2], [-1, 3]].
        wnext = '{'{16'h0080, 16'h0200}, '{16'hFF00, 16'h0300}};
        load_and_switch();
        run_stream(2, -1, -1);
        check("matmul_x1_0", obs_x1[0], 16'hFE80);
        check("matmul_x1_1", obs_x1[1], 16'hFC80);
        check("matmul_x2_0", obs_x2[0], 16'h0800);
        check("matmul_x2_1", obs_x2[1], 16'h1C00);

        // Bubble in the middle of a stream.
        sv[0] = 1'b1; sv[1] = 1'b0; sv[2] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sa0[s] = 16'($urandom_range(0, 16'h0FFF));
            sa1[s] = 16'($urandom_range(0, 16'h0FFF));
        end
        run_stream(3, -1, -1);

        // Double buffering: new random weights shift in mid-stream, switch at iteration 5.
        for (int s = 0; s < 10; s++) begin
            sa0[s] = 16'($urandom);
            sa1[s] = 16'($urandom);
            sv[s]  = 1'($urandom_range(0, 1));
        end
        sv[5] = 1'b1; sv[6] = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 2; k++)
                wnext[r][k] = 16'($urandom);
        run_stream(10, 1, 5);

        // Overflow: 100.0 * 2.0.
        wnext = '{'{16'h0200, 16'h0000}, '{16'h0000, 16'h0000}};
        load_and_switch();
        sa0[0] = 16'h6400; sa1[0] = 16'h0000; sv[0] = 1'b1;
        run_stream(1, -1, -1);
`ifdef SYSTOLIC_SATURATE_EN
        check("overflow_x1", obs_x1[0], 16'h7FFF);
`else
        check("overflow_x1", obs_x1[0], 16'hC800);
`endif

        // Reset mid-stream: outputs clear at once, weights are lost.
        wnext = '{'{16'h0100, 16'h0100}, '{16'h0100, 16'h0100}};
        load_and_switch();
        repeat (3) begin
            @(negedge clk);
            sys_start = 1'b1;
            sys_data_in_1x = 16'h0100;
            sys_data_in_2x = 16'h0100;
        end
        check("pre_rst_valid_x1", {15'b0, sys_valid_out_x1}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("midrst_data_x1", sys_data_out_x1, 16'h0000);
        check("midrst_data_x2", sys_data_out_x2, 16'h0000);
        check("midrst_valid_x1", {15'b0, sys_valid_out_x1}, 16'h0000);
        check("midrst_valid_x2", {15'b0, sys_valid_out_x2}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        repeat (3) @(negedge clk);
        wcur  = '{'{16'h0000, 16'h0000}, '{16'h0000, 16'h0000}};
        wnext = wcur;
        for (int s = 0; s < 4; s++) begin
            sa0[s] = 16'($urandom);
            sa1[s] = 16'($urandom);
            sv[s]  = 1'b1;
        end
        run_stream(4, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- 2x2 weight-stationary systolic array of multiply-accumulate processing elements (PEs) for the tiny-tpu compute core.
- Activations enter from the left, one per row, and flow right. Weights are shifted in from the top, one per column, and are double-buffered per PE. Partial sums flow down.
- Result columns leave at the bottom edge with valid flags.
- Computes C = A·W in signed Q8.8 fixed point; row k of C emerges skewed by one cycle per column.

Parameters:
- DATA_W, 16, width of every data, weight and partial-sum word (signed two's complement).
- FRAC_W, 8, fractional bits of the fixed-point format (Q8.8 at defaults).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sys_data_in_1x  in  DATA_W  activation into row 1 (PE11).
- sys_data_in_2x  in  DATA_W  activation into row 2 (PE21); driver skews it one cycle behind row 1.
- sys_start  in  1  valid flag for the row-1 activation.
- sys_weight_in_x1  in  DATA_W  weight into the top of column 1.
- sys_weight_in_x2  in  DATA_W  weight into the top of column 2.
- sys_accept_w_1  in  1  shift enable for the column-1 shadow weights.
- sys_accept_w_2  in  1  shift enable for the column-2 shadow weights.
- sys_switch_in  in  1  request to copy shadow weights to active weights; enters at PE11.
- sys_data_out_x1  out  DATA_W  column-1 result (PE21 psum).
- sys_data_out_x2  out  DATA_W  column-2 result (PE22 psum).
- sys_valid_out_x1  out  1  column-1 result valid.
- sys_valid_out_x2  out  1  column-2 result valid.

Behaviour:
- Reset: asynchronous, active-high; clk and rst only. While rst is high, all PE registers clear to 0: shadow weight, active weight, input_out, psum_out, valid_out, switch_out. All outputs read 0.
- PE(r,c) registers: shadow weight (wsh), active weight (wact), input_out, psum_out, valid_out, switch_out.
- Weight load: when sys_accept_w_c=1, on each posedge PE1c.wsh <= sys_weight_in_xc and PE2c.wsh <= PE1c.wsh. The first weight loaded lands in row 2, so the driver supplies W[1][c] then W[0][c]. When accept is 0, wsh holds.
- Switch: when a PE's switch_in=1, on the posedge wact <= wsh and switch_out <= 1; otherwise switch_out <= 0. Wiring:
  - PE11 takes sys_switch_in.
  - PE12 and PE21 take PE11.switch_out.
  - PE22 takes PE12.switch_out.
  - A single-cycle pulse therefore activates PE11 at edge n, PE12/PE21 at n+1, PE22 at n+2.
- Accept and switch on the same PE/edge: the switch copies the pre-edge wsh; the shift also occurs.
- MAC, when valid_in=1 at a posedge:
  - product = input_in*wact, signed full precision (2·DATA_W bits).
  - scaled = product >>> FRAC_W, truncated toward −inf, keeping the low DATA_W bits.
  - psum_out <= psum_in + scaled, wrapping (see SATURATE_EN).
  - input_out <= input_in; valid_out <= 1.
- When valid_in=0 at a posedge: psum_out <= 0, input_out <= 0, valid_out <= 0.
- MAC uses wact as held before the edge, so a switch in the same cycle affects the next operation only.
- Datapath wiring:
  - Row 1 top psum_in = 0; PE2c.psum_in = PE1c.psum_out.
  - PE11 valid_in = sys_start; PE21 valid_in = PE11.valid_out; PE12 valid_in = PE11.valid_out; PE22 valid_in = PE21.valid_out.
  - PE12.input_in = PE11.input_out; PE22.input_in = PE21.input_out.
- Latency: row-1 activation for sample k at edge t gives sys_data_out_x1 = C[k][0] after edge t+2 and sys_data_out_x2 = C[k][1] after edge t+3. Each column is a one-sample-per-cycle stream.
- Row-2 input must be presented exactly one cycle after the matching row-1 input; no internal skew buffer.
- Gaps in sys_start produce zero, non-valid bubbles that propagate unchanged.
- Reset mid-stream: all in-flight results and all weights are lost; outputs are 0 on the next evaluation.

Optional Feature:
- Macro SYSTOLIC_SATURATE_EN.
  - Defined: the scaled product and the psum addition saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. −128.0 .. +127.996 in Q8.8.
  - Undefined: two's-complement wrap-around.
  - Timing and latency are identical in both builds.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> all outputs 0 immediately; after release with no stimulus, outputs stay 0.
- Identity load: load W=I, i.e. col1 inputs 0.0 then 1.0, col2 inputs 1.0 then 0.0 one cycle later; pulse switch; stream rows 1.0,5.0 and 2.0,6.0 skewed -> x1 gives 1.0,5.0 (0x0100,0x0500) with valid; x2 gives 2.0,6.0 one cycle later.
- General matmul: W=[[0.5,2],[−1,3]], A=[[1,2],[5,6]] -> x1 = −1.5, −3.5; x2 = 8.0, 28.0.
- Double buffering: shift a new W into shadow while the old W computes -> results use the old W until the switch wave reaches each PE, then the new W.
- Bubble: sys_start 1,0,1 -> outputs valid 1,0,1 with a 0 result in the gap, per-column skew preserved.
- Overflow: 100.0*2.0 -> wraps to −56.0 without SYSTOLIC_SATURATE_EN; 0x7FFF (127.996) with it.
